cheri_err_monitor: RTL and testbench

Parametrised CHERI exception monitor that replaces ad-hoc per-bit latching of the `cheri_err` LED vector in simulation tops and on-FPGA debug logic. It edge-detects the modulated error lines and keeps a sticky per-channel "errored" mask and a saturating occurrence counter for each channel. It timestamps the first occurrence of each channel and delivers {channel, timestamp} records through a valid/ready event queue, in order, without loss. It sits beside `sonata_system`, fed from `cheri_err_o`, and is drained by a reporting process (DPI/`$fdisplay` in Verilator, TL-UL debug register block on FPGA).

---
 rtl/cheri_mon_pkg.sv | 54 +++++
 rtl/cheri_err_monitor_if.sv | 31 +++
 rtl/prim_fifo_sync.sv | 65 ++++++
 rtl/cheri_err_monitor.sv | 93 +++++++++
 tb/tb_cheri_err_monitor.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cheri_mon_pkg.sv
// Shared types and helpers for the CHERI error monitor.
//   cheri_err_e    : channel index of each CHERI error line
//   cheri_evt_t    : {id, timestamp} event record at default widths
//   cheri_err_name : printable channel name for simulation reporting
//   lowest_set     : index of the lowest set bit, used for the push pick
package cheri_mon_pkg;

  localparam int unsigned MaxChannels = 32;
  localparam int unsigned DefIdW      = 4;
  localparam int unsigned DefTsWidth  = 32;

  typedef enum logic [3:0] {
    CheriErrBounds           = 4'd0,
    CheriErrTag              = 4'd1,
    CheriErrSeal             = 4'd2,
    CheriErrPermitEx         = 4'd3,
    CheriErrPermitLd         = 4'd4,
    CheriErrPermitSt         = 4'd5,
    CheriErrPermitStCap      = 4'd6,
    CheriErrPermitStLocal    = 4'd7,
    CheriErrPermitAccSysRegs = 4'd8
  } cheri_err_e;

  typedef struct packed {
    logic [DefIdW-1:0]     id;
    logic [DefTsWidth-1:0] timestamp;
  } cheri_evt_t;

  function automatic string cheri_err_name(input logic [3:0] idx);
    case (idx)
      CheriErrBounds:           return "Bounds";
      CheriErrTag:              return "Tag";
      CheriErrSeal:             return "Seal";
      CheriErrPermitEx:         return "Permit Execute";
      CheriErrPermitLd:         return "Permit Load";
      CheriErrPermitSt:         return "Permit Store";
      CheriErrPermitStCap:      return "Permit Store Cap";
      CheriErrPermitStLocal:    return "Permit Store Local Cap";
      CheriErrPermitAccSysRegs: return "Permit Acc Sys Regs";
      default:                  return "Unknown";
    endcase
  endfunction

  // Scan from the top so the last hit, i.e. the lowest index, wins.
  function automatic logic [4:0] lowest_set(input logic [MaxChannels-1:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = MaxChannels - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cheri_err_monitor_if.sv
// Signal bundle between the error monitor and its driver/consumer.
//   master : drives err_i, clear_i, cnt_sel_i, evt_ready_i; observes the rest
//   slave  : the monitor itself
interface cheri_err_monitor_if #(
  parameter int unsigned ErrWidth = 9,
  parameter int unsigned CntWidth = 16,
  parameter int unsigned TsWidth  = 32
);
  localparam int unsigned IdW = (ErrWidth > 1) ? $clog2(ErrWidth) : 1;

  logic [ErrWidth-1:0] err_i;
  logic                clear_i;
  logic [ErrWidth-1:0] errored_o;
  logic [IdW-1:0]      cnt_sel_i;
  logic [CntWidth-1:0] cnt_o;
  logic                evt_valid_o;
  logic                evt_ready_i;
  logic [IdW-1:0]      evt_id_o;
  logic [TsWidth-1:0]  evt_time_o;
  logic [TsWidth-1:0]  time_o;

  modport master (
    output err_i, clear_i, cnt_sel_i, evt_ready_i,
    input  errored_o, cnt_o, evt_valid_o, evt_id_o, evt_time_o, time_o
  );

  modport slave (
    input  err_i, clear_i, cnt_sel_i, evt_ready_i,
    output errored_o, cnt_o, evt_valid_o, evt_id_o, evt_time_o, time_o
  );
endinterface

// File: rtl/prim_fifo_sync.sv
// Synchronous valid/ready FIFO.
//   clr_i            : synchronous flush, wins over push/pop
//   wvalid/wready/wdata : write side; a push into a full FIFO is accepted
//                      when a pop happens in the same cycle
//   rvalid/rready/rdata : read side; rdata is zero while empty
//   Pass             : when set, an empty FIFO forwards the write straight out
module prim_fifo_sync #(
  parameter int unsigned Width = 16,
  parameter bit          Pass  = 1'b0,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             empty, full, bypass, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(Depth));
  assign bypass   = Pass && empty && wvalid_i;
  assign rvalid_o = !empty || bypass;
  assign rdata_o  = !empty ? mem_q[rptr_q] : (bypass ? wdata_i : '0);
  assign do_pop   = rready_i && !empty;
  assign wready_o = !full || do_pop;
  // A bypassed word taken by the reader the same cycle is never stored.
  assign do_push  = wvalid_i && wready_o && !(bypass && rready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cheri_err_monitor.sv
// CHERI exception monitor: rising-edge detect on the error lines, sticky
// per-channel errored mask, saturating per-channel occurrence counters, and
// an in-order lossless queue of {channel, first-occurrence timestamp} records.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : err_i, clear_i, errored_o, cnt_sel_i/cnt_o,
//                   evt_valid_o/evt_ready_i/evt_id_o/evt_time_o, time_o
module cheri_err_monitor
  import cheri_mon_pkg::*;
#(
  parameter int unsigned ErrWidth  = 9,
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned TsWidth   = 32,
  parameter int unsigned FifoDepth = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  cheri_err_monitor_if.slave bus
);
  localparam int unsigned IdW  = (ErrWidth > 1) ? $clog2(ErrWidth) : 1;
  localparam int unsigned EvtW = IdW + TsWidth;

  logic [TsWidth-1:0]  time_q;
  logic [ErrWidth-1:0] err_q, errored_q, pending_q;
  logic [ErrWidth-1:0] rise, first_hit, push_mask;
  logic [CntWidth-1:0] cnt_q [ErrWidth];
  logic [TsWidth-1:0]  ts_q  [ErrWidth];
  logic [IdW-1:0]      pick_id;
  logic                push_ready, evt_valid;
  logic [EvtW-1:0]     evt_rdata;

  assign rise      = bus.err_i & ~err_q;
  assign first_hit = rise & ~errored_q;
  assign pick_id   = IdW'(lowest_set(MaxChannels'(pending_q)));
  // Only meaningful when something is pending; otherwise it clears a zero bit.
  assign push_mask = push_ready ? (ErrWidth'(1) << pick_id) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      time_q    <= '0;
      err_q     <= '0;
      errored_q <= '0;
      pending_q <= '0;
      for (int i = 0; i < int'(ErrWidth); i++) begin
        cnt_q[i] <= '0;
        ts_q[i]  <= '0;
      end
    end else begin
      time_q <= time_q + TsWidth'(1);
      // Tracks the line even while clearing, so a line held high across a
      // clear does not produce a fresh edge afterwards.
      err_q  <= bus.err_i;
      if (bus.clear_i) begin
        errored_q <= '0;
        pending_q <= '0;
        for (int i = 0; i < int'(ErrWidth); i++) begin
          cnt_q[i] <= '0;
          ts_q[i]  <= '0;
        end
      end else begin
        errored_q <= errored_q | rise;
        pending_q <= (pending_q & ~push_mask) | first_hit;
        for (int i = 0; i < int'(ErrWidth); i++) begin
          if (rise[i] && (cnt_q[i] != {CntWidth{1'b1}})) cnt_q[i] <= cnt_q[i] + CntWidth'(1);
          if (first_hit[i]) ts_q[i] <= time_q;
        end
      end
    end
  end

  prim_fifo_sync #(
    .Width (EvtW),
    .Pass  (1'b0),
    .Depth (FifoDepth)
  ) u_evt_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (bus.clear_i),
    .wvalid_i (|pending_q),
    .wready_o (push_ready),
    .wdata_i  ({pick_id, ts_q[pick_id]}),
    .rvalid_o (evt_valid),
    .rready_i (bus.evt_ready_i),
    .rdata_o  (evt_rdata)
  );

  assign bus.evt_valid_o = evt_valid;
  assign bus.evt_id_o    = evt_rdata[EvtW-1 -: IdW];
  assign bus.evt_time_o  = evt_rdata[TsWidth-1:0];
  assign bus.errored_o   = errored_q;
  assign bus.time_o      = time_q;
  assign bus.cnt_o       = (32'(bus.cnt_sel_i) < ErrWidth) ? cnt_q[bus.cnt_sel_i] : '0;

endmodule

// File: tb/tb_cheri_err_monitor.sv
`timescale 1ns/1ps
module tb_cheri_err_monitor;
  import cheri_mon_pkg::*;

  localparam int NCH = 9;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] err   = '0;
  logic       clear = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] sel   = '0;

  always #5 clk = ~clk;

  // dut_a: default parameters. dut_b: 4-bit counters, single-entry queue.
  cheri_err_monitor_if                 if_a ();
  cheri_err_monitor_if #(.CntWidth(4)) if_b ();

  assign if_a.err_i = err;   assign if_a.clear_i = clear;
  assign if_a.cnt_sel_i = sel; assign if_a.evt_ready_i = ready;
  assign if_b.err_i = err;   assign if_b.clear_i = clear;
  assign if_b.cnt_sel_i = sel; assign if_b.evt_ready_i = ready;

  cheri_err_monitor dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(if_a));
  cheri_err_monitor #(.CntWidth(4), .FifoDepth(1)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(if_b));

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(string name, int m, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h required %0h at %0t", name, m, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] o_errd(int m); return (m == 0) ? 32'(if_a.errored_o)   : 32'(if_b.errored_o);   endfunction
  function automatic logic [31:0] o_cnt (int m); return (m == 0) ? 32'(if_a.cnt_o)       : 32'(if_b.cnt_o);       endfunction
  function automatic logic [31:0] o_vld (int m); return (m == 0) ? 32'(if_a.evt_valid_o) : 32'(if_b.evt_valid_o); endfunction
  function automatic logic [31:0] o_id  (int m); return (m == 0) ? 32'(if_a.evt_id_o)    : 32'(if_b.evt_id_o);    endfunction
  function automatic logic [31:0] o_tim (int m); return (m == 0) ? if_a.evt_time_o       : if_b.evt_time_o;       endfunction
  function automatic logic [31:0] o_now (int m); return (m == 0) ? if_a.time_o           : if_b.time_o;           endfunction

  // ---------------- reference model: queue of records per DUT ----------------
  logic [8:0]  m_prev;
  logic [31:0] m_time;
  logic [8:0]  m_errored [2];
  logic [8:0]  m_pending [2];
  int unsigned m_cnt [2][NCH];
  logic [31:0] m_ts  [2][NCH];
  cheri_evt_t  mq [2][$];

  function automatic int unsigned cnt_max(int m); return (m == 0) ? 65535 : 15; endfunction
  function automatic int          q_depth(int m); return (m == 0) ? 4 : 1;      endfunction

  task automatic model_reset();
    m_prev = '0;
    m_time = '0;
    for (int m = 0; m < 2; m++) begin
      m_errored[m] = '0;
      m_pending[m] = '0;
      mq[m].delete();
      for (int i = 0; i < NCH; i++) begin
        m_cnt[m][i] = 0;
        m_ts[m][i]  = '0;
      end
    end
  endtask

  task automatic model_clock();
    logic [8:0] rise;
    bit         pop, room;
    int         pick;
    cheri_evt_t ev;
    if (!rst_n) return;
    rise = err & ~m_prev;
    for (int m = 0; m < 2; m++) begin
      if (clear) begin
        m_errored[m] = '0;
        m_pending[m] = '0;
        mq[m].delete();
        for (int i = 0; i < NCH; i++) begin
          m_cnt[m][i] = 0;
          m_ts[m][i]  = '0;
        end
      end else begin
        pop  = (mq[m].size() > 0) && ready;
        room = (mq[m].size() < q_depth(m)) || pop;
        pick = -1;
        for (int i = 0; i < NCH; i++)
          if (m_pending[m][i] && pick < 0) pick = i;
        if (pop) void'(mq[m].pop_front());
        if (pick >= 0 && room) begin
          ev.id        = 4'(pick);
          ev.timestamp = m_ts[m][pick];
          mq[m].push_back(ev);
          m_pending[m][pick] = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
          if (rise[i]) begin
            if (m_cnt[m][i] < cnt_max(m)) m_cnt[m][i]++;
            if (!m_errored[m][i]) begin
              m_errored[m][i] = 1'b1;
              m_pending[m][i] = 1'b1;
              m_ts[m][i]      = m_time;
            end
          end
        end
      end
    end
    m_prev = err;
    m_time = m_time + 32'd1;
  endtask

  task automatic check_all();
    int unsigned exp_cnt;
    if (!rst_n) return;
    for (int m = 0; m < 2; m++) begin
      exp_cnt = 0;
      if (sel < 4'd9) exp_cnt = m_cnt[m][sel];
      chk("time_o", m, o_now(m), m_time);
      chk("errored_o", m, o_errd(m), 32'(m_errored[m]));
      chk("cnt_o", m, o_cnt(m), exp_cnt);
      chk("evt_valid_o", m, o_vld(m), 32'(mq[m].size() > 0));
      if (mq[m].size() > 0) begin
        chk("evt_id_o", m, o_id(m), 32'(mq[m][0].id));
        chk("evt_time_o", m, o_tim(m), mq[m][0].timestamp);
      end
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
  task automatic drive(logic [8:0] e, logic r, logic c);
    err = e; ready = r; clear = c;
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; err = '0; clear = 1'b0; ready = 1'b0; sel = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [8:0]  err;
    logic        rdy;
    logic        vld;
    logic [3:0]  id;
    logic [31:0] ts;
  } vec_t;
  vec_t tbl [12];

  int         got [2][$];
  int         n3 [2];
  logic [8:0] e_v;
  logic       c_v, r_v;

  initial begin
    for (int i = 0; i < 12; i++) tbl[i] = '{err: 9'h000, rdy: 1'b1, vld: 1'b0, id: 4'd0, ts: 32'd0};
    tbl[5].err = 9'h111;
    tbl[7] = '{err: 9'h000, rdy: 1'b1, vld: 1'b1, id: 4'd0, ts: 32'd5};
    tbl[8] = '{err: 9'h000, rdy: 1'b1, vld: 1'b1, id: 4'd4, ts: 32'd5};
    tbl[9] = '{err: 9'h000, rdy: 1'b1, vld: 1'b1, id: 4'd8, ts: 32'd5};

    // Reset values.
    do_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_errored", m, o_errd(m), 0);
      chk("rst_cnt", m, o_cnt(m), 0);
      chk("rst_valid", m, o_vld(m), 0);
      chk("rst_id", m, o_id(m), 0);
      chk("rst_evt_time", m, o_tim(m), 0);
      chk("rst_time", m, o_now(m), 0);
    end

    // Channel 0 rises in cycle 10 and is held.
    for (int t = 0; t < 18; t++) begin
      drive((t >= 10 && t < 16) ? 9'h001 : 9'h000, t == 14, 1'b0);
      for (int m = 0; m < 2; m++) begin
        chk("A_time", m, o_now(m), t);
        if (t == 10) chk("A_errored_n", m, o_errd(m), 0);
        if (t >= 11) begin
          chk("A_errored", m, o_errd(m), 32'h001);
          chk("A_cnt", m, o_cnt(m), 1);
        end
        if (t == 11) chk("A_valid_early", m, o_vld(m), 0);
        if (t == 12 || t == 13 || t == 14) begin
          chk("A_valid", m, o_vld(m), 1);
          chk("A_id", m, o_id(m), 0);
          chk("A_ts", m, o_tim(m), 10);
        end
        if (t >= 15) chk("A_drained", m, o_vld(m), 0);
      end
      tick();
    end

    // Three simultaneous first occurrences, consumer always ready.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].err, tbl[i].rdy, 1'b0);
      for (int m = 0; m < 2; m++) begin
        chk("B_time", m, o_now(m), i);
        chk("B_valid", m, o_vld(m), 32'(tbl[i].vld));
        if (tbl[i].vld) begin
          chk("B_id", m, o_id(m), 32'(tbl[i].id));
          chk("B_ts", m, o_tim(m), tbl[i].ts);
        end
      end
      tick();
    end

    // All channels at once with the consumer stalled, then drained.
    do_reset();
    for (int t = 0; t < 10; t++) begin
      drive((t == 3) ? 9'h1FF : 9'h000, 1'b0, 1'b0);
      if (t == 9) begin
        for (int m = 0; m < 2; m++) begin
          chk("C_errored", m, o_errd(m), 32'h1FF);
          chk("C_valid", m, o_vld(m), 1);
          chk("C_head_id", m, o_id(m), 0);
          chk("C_head_ts", m, o_tim(m), 3);
        end
      end
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      drive(9'h000, 1'b1, 1'b0);
      for (int m = 0; m < 2; m++) begin
        if (o_vld(m) == 1) begin
          got[m].push_back(int'(o_id(m)));
          chk("C_rec_ts", m, o_tim(m), 3);
        end
      end
      tick();
    end
    for (int m = 0; m < 2; m++) begin
      chk("C_rec_count", m, got[m].size(), 9);
      for (int k = 0; k < got[m].size() && k < 9; k++) chk("C_rec_order", m, got[m][k], k);
    end

    // Channel 3 toggling every cycle: counter saturation and a single record.
    do_reset();
    sel = 4'd3;
    n3[0] = 0; n3[1] = 0;
    for (int t = 0; t < 46; t++) begin
      drive((t < 40 && (t % 2) == 0) ? 9'h008 : 9'h000, 1'b1, 1'b0);
      for (int m = 0; m < 2; m++)
        if (o_vld(m) == 1 && o_id(m) == 3) n3[m]++;
      tick();
    end
    #1;
    chk("D_cnt_full", 0, o_cnt(0), 20);
    chk("D_cnt_sat", 1, o_cnt(1), 15);
    for (int m = 0; m < 2; m++) chk("D_one_record", m, n3[m], 1);

    // Clear coinciding with a channel 2 edge while records are queued.
    do_reset();
    for (int t = 0; t < 12; t++) begin
      e_v = 9'h000; c_v = 1'b0;
      if (t >= 2 && t <= 5) e_v = 9'h003;
      if (t == 6) begin e_v = 9'h007; c_v = 1'b1; end
      if (t == 7) e_v = 9'h004;
      if (t >= 9) e_v = 9'h004;
      sel = 4'd0;
      drive(e_v, 1'b0, c_v);
      for (int m = 0; m < 2; m++) begin
        if (t == 5) begin
          chk("E_pre_valid", m, o_vld(m), 1);
          chk("E_pre_errored", m, o_errd(m), 32'h003);
        end
        if (t == 7 || t == 8) begin
          chk("E_clr_errored", m, o_errd(m), 0);
          chk("E_clr_valid", m, o_vld(m), 0);
        end
        if (t == 11) begin
          chk("E_new_valid", m, o_vld(m), 1);
          chk("E_new_id", m, o_id(m), 2);
          chk("E_new_ts", m, o_tim(m), 9);
        end
      end
      if (t == 7) begin
        for (int s = 0; s < 3; s++) begin
          sel = 4'(s);
          #1;
          for (int m = 0; m < 2; m++) chk("E_clr_cnt", m, o_cnt(m), 0);
        end
        sel = 4'd0;
      end
      tick();
    end

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      e_v = err ^ (9'($urandom) & 9'($urandom) & 9'($urandom));
      c_v = ($urandom_range(0, 59) == 0);
      r_v = ($urandom_range(0, 3) != 0);
      sel = 4'($urandom_range(0, 15));
      drive(e_v, r_v, c_v);
      tick();
    end

    // Asynchronous reset while a record waits on a stalled consumer.
    drive(9'h000, 1'b0, 1'b1);
    tick();
    for (int t = 0; t < 4; t++) begin
      drive((t == 0) ? 9'h020 : 9'h000, 1'b0, 1'b0);
      tick();
    end
    for (int m = 0; m < 2; m++) chk("G_valid_before", m, o_vld(m), 1);
    sel = 4'd5;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("G_errored", m, o_errd(m), 0);
      chk("G_cnt", m, o_cnt(m), 0);
      chk("G_valid", m, o_vld(m), 0);
      chk("G_id", m, o_id(m), 0);
      chk("G_evt_time", m, o_tim(m), 0);
      chk("G_time", m, o_now(m), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(9'h000, 1'b0, 1'b0);
    tick();
    drive(9'h000, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) chk("G_time_restart", m, o_now(m), 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
